// File: rtl/axis_to_aximm.sv
// Write-only AXI4 master: streams AXIS beats to memory as serial INCR bursts that never cross 4KB.
// Optional BRESP error capture is enabled by defining AXIS_TO_AXIMM_BRESP_CHECK_EN.
module axis_to_aximm #(
   parameter int DW        = 512,
   parameter int AW        = 64,
   parameter int BURST_LEN = 64,
   parameter int CW        = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [CW-1:0]     cfg_beats,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [DW-1:0]     AXIS_IN_TDATA,
   input  logic [DW/8-1:0]   AXIS_IN_TKEEP,
   input  logic              AXIS_IN_TLAST,
   input  logic              AXIS_IN_TVALID,
   output logic              AXIS_IN_TREADY,
   output logic [AW-1:0]     M_AXI_AWADDR,
   output logic [7:0]        M_AXI_AWLEN,
   output logic              M_AXI_AWVALID,
   input  logic              M_AXI_AWREADY,
   output logic [3:0]        M_AXI_AWID,
   output logic [2:0]        M_AXI_AWSIZE,
   output logic [1:0]        M_AXI_AWBURST,
   output logic              M_AXI_AWLOCK,
   output logic [3:0]        M_AXI_AWCACHE,
   output logic [3:0]        M_AXI_AWQOS,
   output logic [2:0]        M_AXI_AWPROT,
   output logic [DW-1:0]     M_AXI_WDATA,
   output logic [DW/8-1:0]   M_AXI_WSTRB,
   output logic              M_AXI_WVALID,
   output logic              M_AXI_WLAST,
   input  logic              M_AXI_WREADY,
   input  logic [1:0]        M_AXI_BRESP,
   input  logic              M_AXI_BVALID,
   output logic              M_AXI_BREADY
);

   // state  | meaning
   // IDLE   | waiting for start
   // ADDR   | AWVALID held for the current burst
   // DATA   | stream passed through to W channel
   // RESP   | waiting for the B handshake
   // DONE   | one-cycle done pulse
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_RESP = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int BPB     = DW / 8;
   localparam int BPB_LOG = $clog2(BPB);

   logic [2:0]    state;
   logic [AW-1:0] addr_q;
   logic [CW-1:0] remaining;
   logic [CW-1:0] beat_cnt;
   logic [12:0]   to_4k;
   logic [12:0]   lim;
   logic          rem_lt;
   logic [8:0]    len;
   logic          last_beat;
   logic          w_fire;
   logic          unused_ok;

   // addr_q and remaining are frozen from ADDR through RESP, so len is stable for the whole burst
   assign to_4k  = (13'd4096 - {1'b0, addr_q[11:0]}) >> BPB_LOG;
   assign lim    = (to_4k < 13'(BURST_LEN)) ? to_4k : 13'(BURST_LEN);
   assign rem_lt = {13'd0, remaining} < {{CW{1'b0}}, lim};
   assign len    = rem_lt ? remaining[8:0] : lim[8:0];

   assign last_beat = (beat_cnt == (CW'(len) - CW'(1)));
   assign w_fire    = (state == S_DATA) && AXIS_IN_TVALID && M_AXI_WREADY;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         remaining <= '0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q    <= cfg_addr;
                  remaining <= cfg_beats;
                  beat_cnt  <= '0;
                  state     <= (cfg_beats == '0) ? S_DONE : S_ADDR;
               end
            end
            S_ADDR: begin
               if (M_AXI_AWREADY) state <= S_DATA;
            end
            S_DATA: begin
               if (w_fire) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     state    <= S_RESP;
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            S_RESP: begin
               if (M_AXI_BVALID) begin
                  addr_q    <= addr_q + (AW'(len) << BPB_LOG);
                  remaining <= remaining - CW'(len);
                  state     <= (remaining == CW'(len)) ? S_DONE : S_ADDR;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef AXIS_TO_AXIMM_BRESP_CHECK_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         err_q <= 1'b0;
      end else if (state == S_IDLE && start) begin
         err_q <= 1'b0;
      end else if (state == S_RESP && M_AXI_BVALID && M_AXI_BRESP != 2'b00) begin
         err_q <= 1'b1;
      end
   end

   assign err       = err_q;
   assign unused_ok = AXIS_IN_TLAST;
`else
   assign err       = 1'b0;
   assign unused_ok = ^{AXIS_IN_TLAST, M_AXI_BRESP};
`endif

   assign busy = (state == S_ADDR) || (state == S_DATA) || (state == S_RESP);
   assign done = (state == S_DONE);

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWLEN   = 8'(len - 9'd1);
   assign M_AXI_AWVALID = (state == S_ADDR);
   assign M_AXI_AWID    = 4'd0;
   assign M_AXI_AWSIZE  = 3'(BPB_LOG);
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = 4'b0011;
   assign M_AXI_AWQOS   = 4'd0;
   assign M_AXI_AWPROT  = 3'b000;

   assign M_AXI_WDATA    = AXIS_IN_TDATA;
   assign M_AXI_WSTRB    = AXIS_IN_TKEEP;
   assign M_AXI_WVALID   = (state == S_DATA) && AXIS_IN_TVALID;
   assign M_AXI_WLAST    = (state == S_DATA) && last_beat;
   assign AXIS_IN_TREADY = (state == S_DATA) && M_AXI_WREADY;
   assign M_AXI_BREADY   = (state == S_RESP);

endmodule
